mem_access_unit: RTL and testbench

//  M-stage load/store engine. Consumes the EX/MEM register outputs (address = M_alu_out,

---
 rtl/mem_access_unit_pkg.sv | 51 +++++
 rtl/mem_access_unit_lsu_align.sv | 55 +++++
 rtl/mem_access_unit.sv | 168 ++++++++++++++++
 tb/tb_mem_access_unit.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_unit_pkg.sv
// Shared types and constants for the M-stage load/store unit.
// Holds funct3 encodings, the access FSM states and legality helpers.
package mem_access_unit_pkg;

  localparam int XLEN  = 32;
  localparam int BYTES = XLEN / 8;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2,
    DONE = 2'd3
  } state_t;

  // Width/sign code is meaningful for this direction of access.
  function automatic logic f3_legal(
    input logic [2:0] f3,
    input logic       is_store
  );
    logic ok;
    ok = 1'b0;
    unique case (f3)
      F3_B, F3_H, F3_W: ok = 1'b1;
      F3_BU, F3_HU:     ok = !is_store;
      default:          ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Halfwords need even addresses, words need 4-byte alignment.
  function automatic logic f3_misaligned(
    input logic [2:0] f3,
    input logic [1:0] lo
  );
    logic bad;
    bad = 1'b0;
    unique case (f3)
      F3_H, F3_HU: bad = lo[0];
      F3_W:        bad = (lo != 2'b00);
      default:     bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_access_unit_lsu_align.sv
// Lane steering for the load/store unit: byte enables, store
// replication and load extract/extend. Purely combinational.
module lsu_align
  import mem_access_unit_pkg::*;
(
  input  logic [2:0]       st_funct3,
  input  logic [1:0]       st_offset,
  input  logic [XLEN-1:0]  st_data,
  output logic [BYTES-1:0] st_be,
  output logic [XLEN-1:0]  st_wdata,
  input  logic [2:0]       ld_funct3,
  input  logic [1:0]       ld_offset,
  input  logic [XLEN-1:0]  ld_raw,
  output logic [XLEN-1:0]  ld_word
);

  logic [XLEN-1:0] shifted;
  logic [4:0]      shamt;

  // Store side: lane mask and replicated data from the size code.
  always_comb begin
    st_be    = 4'b1111;
    st_wdata = st_data;
    unique case (st_funct3)
      F3_B, F3_BU: begin
        st_be    = 4'b0001 << st_offset;
        st_wdata = {4{st_data[7:0]}};
      end
      F3_H, F3_HU: begin
        st_be    = 4'b0011 << st_offset;
        st_wdata = {2{st_data[15:0]}};
      end
      default: begin
        st_be    = 4'b1111;
        st_wdata = st_data;
      end
    endcase
  end

  assign shamt   = {ld_offset, 3'b000};
  assign shifted = ld_raw >> shamt;

  // Load side: move addressed lane to bit 0, then extend.
  always_comb begin
    ld_word = shifted;
    unique case (ld_funct3)
      F3_B:    ld_word = {{24{shifted[7]}}, shifted[7:0]};
      F3_BU:   ld_word = {24'b0, shifted[7:0]};
      F3_H:    ld_word = {{16{shifted[15]}}, shifted[15:0]};
      F3_HU:   ld_word = {16'b0, shifted[15:0]};
      default: ld_word = shifted;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// M-stage load/store engine: req/gnt/rvalid handshake to data
// memory, pipeline stall while busy, aligned load result.
module mem_access_unit
  import mem_access_unit_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             M_mem_read,
  input  logic             M_mem_write,
  input  logic [2:0]       M_funct3,
  input  logic [XLEN-1:0]  M_alu_out,
  input  logic [XLEN-1:0]  M_rs2_data_out,
  output logic             dm_req,
  output logic             dm_we,
  output logic [XLEN-1:0]  dm_addr,
  output logic [XLEN-1:0]  dm_wdata,
  output logic [BYTES-1:0] dm_be,
  input  logic             dm_gnt,
  input  logic             dm_rvalid,
  input  logic [XLEN-1:0]  dm_rdata,
  output logic             lsu_stall,
  output logic [XLEN-1:0]  ld_data,
  output logic             ld_valid,
  output logic             lsu_fault
);

  state_t state_q;
  state_t state_d;

  logic op;
  logic fault;
  logic legal;

  logic [BYTES-1:0] st_be;
  logic [XLEN-1:0]  st_wdata;
  logic [XLEN-1:0]  ld_word;

  // Copy of the load's size/offset taken when the request issues.
  logic [2:0] f3_q;
  logic [2:0] f3_d;
  logic [1:0] off_q;
  logic [1:0] off_d;

  logic             req_d;
  logic             we_d;
  logic [XLEN-1:0]  addr_d;
  logic [XLEN-1:0]  wdata_d;
  logic [BYTES-1:0] be_d;
  logic [XLEN-1:0]  ld_data_d;
  logic             ld_valid_d;
  logic             fault_d;

  assign op    = M_mem_read | M_mem_write;
  assign fault = op && ((M_mem_read && M_mem_write)
              || !f3_legal(M_funct3, M_mem_write)
              || f3_misaligned(M_funct3, M_alu_out[1:0]));
  assign legal = op && !fault;

  // Pipeline holds until the access finishes; DONE lets M advance.
  assign lsu_stall = legal && (state_q != DONE);

  lsu_align u_align (
    .st_funct3 (M_funct3),
    .st_offset (M_alu_out[1:0]),
    .st_data   (M_rs2_data_out),
    .st_be     (st_be),
    .st_wdata  (st_wdata),
    .ld_funct3 (f3_q),
    .ld_offset (off_q),
    .ld_raw    (dm_rdata),
    .ld_word   (ld_word)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic for the access sequence.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (legal) state_d = REQ;
      REQ: begin
        if (dm_gnt) begin
          if (dm_we || dm_rvalid) state_d = DONE;
          else                    state_d = RESP;
        end
      end
      RESP: if (dm_rvalid) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values for the registered memory-side and result outputs.
  always_comb begin
    req_d      = dm_req;
    we_d       = dm_we;
    addr_d     = dm_addr;
    wdata_d    = dm_wdata;
    be_d       = dm_be;
    ld_data_d  = ld_data;
    ld_valid_d = 1'b0;
    fault_d    = 1'b0;
    f3_d       = f3_q;
    off_d      = off_q;
    unique case (state_q)
      IDLE: begin
        fault_d = fault;
        if (legal) begin
          req_d   = 1'b1;
          we_d    = M_mem_write;
          addr_d  = {M_alu_out[XLEN-1:2], 2'b00};
          wdata_d = st_wdata;
          be_d    = st_be;
          f3_d    = M_funct3;
          off_d   = M_alu_out[1:0];
        end
      end
      REQ: begin
        if (dm_gnt) begin
          req_d = 1'b0;
          if (!dm_we && dm_rvalid) begin
            ld_data_d  = ld_word;
            ld_valid_d = 1'b1;
          end
        end
      end
      RESP: begin
        if (dm_rvalid) begin
          ld_data_d  = ld_word;
          ld_valid_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Output and side-state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      dm_req    <= 1'b0;
      dm_we     <= 1'b0;
      dm_addr   <= '0;
      dm_wdata  <= '0;
      dm_be     <= '0;
      ld_data   <= '0;
      ld_valid  <= 1'b0;
      lsu_fault <= 1'b0;
      f3_q      <= '0;
      off_q     <= '0;
    end else begin
      dm_req    <= req_d;
      dm_we     <= we_d;
      dm_addr   <= addr_d;
      dm_wdata  <= wdata_d;
      dm_be     <= be_d;
      ld_data   <= ld_data_d;
      ld_valid  <= ld_valid_d;
      lsu_fault <= fault_d;
      f3_q      <= f3_d;
      off_q     <= off_d;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with request/load scoreboards.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        M_mem_read;
  logic        M_mem_write;
  logic [2:0]  M_funct3;
  logic [31:0] M_alu_out;
  logic [31:0] M_rs2_data_out;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [3:0]  dm_be;
  logic        dm_gnt;
  logic        dm_rvalid;
  logic [31:0] dm_rdata;
  logic        lsu_stall;
  logic [31:0] ld_data;
  logic        ld_valid;
  logic        lsu_fault;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } req_t;

  req_t        req_q[$];
  logic [31:0] ld_q[$];

  always #5 clk = ~clk;

  mem_access_unit dut (
    .clk            (clk),
    .rst            (rst),
    .M_mem_read     (M_mem_read),
    .M_mem_write    (M_mem_write),
    .M_funct3       (M_funct3),
    .M_alu_out      (M_alu_out),
    .M_rs2_data_out (M_rs2_data_out),
    .dm_req         (dm_req),
    .dm_we          (dm_we),
    .dm_addr        (dm_addr),
    .dm_wdata       (dm_wdata),
    .dm_be          (dm_be),
    .dm_gnt         (dm_gnt),
    .dm_rvalid      (dm_rvalid),
    .dm_rdata       (dm_rdata),
    .lsu_stall      (lsu_stall),
    .ld_data        (ld_data),
    .ld_valid       (ld_valid),
    .lsu_fault      (lsu_fault)
  );

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h",
             tag, obs, exp);
    end
  endtask

  task automatic check_req(input string tag, input req_t r);
    check({tag, "_req"}, {31'b0, dm_req}, 32'd1);
    check({tag, "_we"}, {31'b0, dm_we}, {31'b0, r.we});
    check({tag, "_addr"}, dm_addr, r.addr);
    check({tag, "_be"}, {28'b0, dm_be}, {28'b0, r.be});
    if (r.we) check({tag, "_wdata"}, dm_wdata, r.wdata);
  endtask

  task automatic wait_req();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (dm_req === 1'b1) break;
    end
  endtask

  task automatic wait_ldv();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (ld_valid === 1'b1) break;
    end
  endtask

  task automatic do_store(input logic [2:0]  f3,
                          input logic [31:0] addr,
                          input logic [31:0] data,
                          input logic [3:0]  ebe,
                          input logic [31:0] ewd,
                          input int          gdly);
    req_t r;
    req_q.push_back(req_t'{1'b1, {addr[31:2], 2'b00}, ebe, ewd});
    @(posedge clk); #1;
    M_mem_write    = 1'b1;
    M_funct3       = f3;
    M_alu_out      = addr;
    M_rs2_data_out = data;
    @(negedge clk);
    check("st_stall_idle", {31'b0, lsu_stall}, 32'd1);
    wait_req();
    r = req_q.pop_front();
    check_req("st", r);
    for (int i = 0; i < gdly; i++) begin
      @(negedge clk);
      check_req("st_hold", r);
      check("st_hold_stall", {31'b0, lsu_stall}, 32'd1);
    end
    dm_gnt = 1'b1;
    @(posedge clk); #1;
    dm_gnt = 1'b0;
    @(negedge clk);
    check("st_done_req", {31'b0, dm_req}, 32'd0);
    check("st_done_stall", {31'b0, lsu_stall}, 32'd0);
    @(posedge clk); #1;
    M_mem_write = 1'b0;
  endtask

  task automatic do_load(input logic [2:0]  f3,
                         input logic [31:0] addr,
                         input logic [31:0] rdata,
                         input logic [3:0]  ebe,
                         input logic [31:0] eld,
                         input int          gdly,
                         input int          rvdly,
                         input bit          same);
    req_t        r;
    logic [31:0] e;
    req_q.push_back(req_t'{1'b0, {addr[31:2], 2'b00}, ebe, 32'h0});
    ld_q.push_back(eld);
    @(posedge clk); #1;
    M_mem_read = 1'b1;
    M_funct3   = f3;
    M_alu_out  = addr;
    @(negedge clk);
    check("ld_stall_idle", {31'b0, lsu_stall}, 32'd1);
    wait_req();
    r = req_q.pop_front();
    check_req("ld", r);
    for (int i = 0; i < gdly; i++) begin
      @(negedge clk);
      check_req("ld_hold", r);
    end
    dm_gnt = 1'b1;
    if (same) begin
      dm_rvalid = 1'b1;
      dm_rdata  = rdata;
    end
    @(posedge clk); #1;
    dm_gnt    = 1'b0;
    dm_rvalid = 1'b0;
    if (!same) begin
      for (int i = 0; i < rvdly; i++) begin
        @(negedge clk);
        check("ld_resp_stall", {31'b0, lsu_stall}, 32'd1);
        check("ld_resp_req", {31'b0, dm_req}, 32'd0);
      end
      dm_rvalid = 1'b1;
      dm_rdata  = rdata;
      @(posedge clk); #1;
      dm_rvalid = 1'b0;
    end
    wait_ldv();
    check("ld_valid", {31'b0, ld_valid}, 32'd1);
    e = ld_q.pop_front();
    check("ld_data", ld_data, e);
    check("ld_done_stall", {31'b0, lsu_stall}, 32'd0);
    @(posedge clk); #1;
    M_mem_read = 1'b0;
    dm_rdata   = 32'h0;
    @(negedge clk);
    check("ld_valid_pulse", {31'b0, ld_valid}, 32'd0);
  endtask

  task automatic do_fault(input string       tag,
                          input logic        rd,
                          input logic        wr,
                          input logic [2:0]  f3,
                          input logic [31:0] addr);
    @(posedge clk); #1;
    M_mem_read  = rd;
    M_mem_write = wr;
    M_funct3    = f3;
    M_alu_out   = addr;
    @(negedge clk);
    check({tag, "_stall"}, {31'b0, lsu_stall}, 32'd0);
    @(posedge clk); #1;
    M_mem_read  = 1'b0;
    M_mem_write = 1'b0;
    @(negedge clk);
    check({tag, "_pulse"}, {31'b0, lsu_fault}, 32'd1);
    check({tag, "_noreq"}, {31'b0, dm_req}, 32'd0);
    @(negedge clk);
    check({tag, "_clear"}, {31'b0, lsu_fault}, 32'd0);
    check({tag, "_noreq2"}, {31'b0, dm_req}, 32'd0);
  endtask

  initial begin
    rst            = 1'b1;
    M_mem_read     = 1'b0;
    M_mem_write    = 1'b0;
    M_funct3       = 3'b000;
    M_alu_out      = 32'h0;
    M_rs2_data_out = 32'h0;
    dm_gnt         = 1'b0;
    dm_rvalid      = 1'b0;
    dm_rdata       = 32'h0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_req", {31'b0, dm_req}, 32'd0);
    check("rst_be", {28'b0, dm_be}, 32'd0);
    check("rst_addr", dm_addr, 32'h0);
    check("rst_ld_data", ld_data, 32'h0);
    check("rst_stall", {31'b0, lsu_stall}, 32'd0);

    do_store(3'b010, 32'h100, 32'hDEADBEEF, 4'b1111, 32'hDEADBEEF, 2);
    do_store(3'b000, 32'h103, 32'h000000A5, 4'b1000, 32'hA5A5A5A5, 0);
    do_store(3'b001, 32'h102, 32'h1234ABCD, 4'b1100, 32'hABCDABCD, 1);

    do_load(3'b000, 32'h102, 32'h12F45678, 4'b0100,
            32'hFFFFFFF4, 1, 1, 1'b0);
    do_load(3'b100, 32'h102, 32'h12F45678, 4'b0100,
            32'h000000F4, 0, 0, 1'b0);
    do_load(3'b001, 32'h102, 32'h80017FFF, 4'b1100,
            32'hFFFF8001, 0, 0, 1'b1);
    do_load(3'b101, 32'h100, 32'h1234F00D, 4'b0011,
            32'h0000F00D, 1, 2, 1'b0);
    do_load(3'b010, 32'h40, 32'hCAFEF00D, 4'b1111,
            32'hCAFEF00D, 0, 0, 1'b1);

    do_fault("f_lh_odd", 1'b1, 1'b0, 3'b001, 32'h101);
    do_fault("f_sw_mis", 1'b0, 1'b1, 3'b010, 32'h102);
    do_fault("f_sbu", 1'b0, 1'b1, 3'b100, 32'h100);
    do_fault("f_both", 1'b1, 1'b1, 3'b010, 32'h100);
    do_fault("f_f3_011", 1'b1, 1'b0, 3'b011, 32'h100);

    // Reset while waiting for rvalid; late rvalid must be ignored.
    @(posedge clk); #1;
    M_mem_read = 1'b1;
    M_funct3   = 3'b010;
    M_alu_out  = 32'h200;
    wait_req();
    check("rr_req", {31'b0, dm_req}, 32'd1);
    dm_gnt = 1'b1;
    @(posedge clk); #1;
    dm_gnt = 1'b0;
    @(negedge clk);
    check("rr_resp_stall", {31'b0, lsu_stall}, 32'd1);
    rst        = 1'b1;
    M_mem_read = 1'b0;
    @(posedge clk); #1;
    rst       = 1'b0;
    dm_rvalid = 1'b1;
    dm_rdata  = 32'h55AA55AA;
    @(posedge clk); #1;
    dm_rvalid = 1'b0;
    @(negedge clk);
    check("rr_ld_valid", {31'b0, ld_valid}, 32'd0);
    check("rr_ld_data", ld_data, 32'h0);
    check("rr_req0", {31'b0, dm_req}, 32'd0);
    check("rr_addr", dm_addr, 32'h0);
    check("rr_wdata", dm_wdata, 32'h0);
    check("rr_be", {28'b0, dm_be}, 32'd0);
    check("rr_stall", {31'b0, lsu_stall}, 32'd0);
    check("rr_fault", {31'b0, lsu_fault}, 32'd0);

    // Unit must still work after the abort.
    do_load(3'b010, 32'h300, 32'h0BADF00D, 4'b1111,
            32'h0BADF00D, 0, 1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
